// File: rtl/ps2_dir_receiver_if.sv
// Bus between the PS/2 receiver and the snake game FSM.
// The master side is the receiver; the slave side is the keyboard pins plus the game consumer.
interface ps2_dir_receiver_if;
  logic       PS2_CLK;
  logic       PS2_DATA;
  logic [1:0] DIR;
  logic       DIR_VALID;
  logic [7:0] SCAN;
  logic       ERR;
  logic [1:0] fsm_state;

  // Handshake: DIR_VALID is a one-cycle strobe with no ready/backpressure.
  // DIR is stable between strobes, so a consumer may sample it at any time.
  // A strobe marks a newly accepted direction, which may equal the previous one.
  // ERR is a one-cycle strobe for a dropped frame and is never high with DIR_VALID.
  // fsm_state mirrors the frame FSM: 0 idle, 1 data, 2 parity, 3 stop.
  modport master (
    input  PS2_CLK,
    input  PS2_DATA,
    output DIR,
    output DIR_VALID,
    output SCAN,
    output ERR,
    output fsm_state
  );

  modport slave (
    output PS2_CLK,
    output PS2_DATA,
    input  DIR,
    input  DIR_VALID,
    input  SCAN,
    input  ERR,
    input  fsm_state
  );
endinterface

// File: rtl/ps2_dir_receiver.sv
// PS/2 device-to-host frame receiver that turns arrow-key make codes into a 2-bit direction.
// Optional macro PS2_WASD_EN also maps the non-extended W/S/A/D make codes.
module ps2_dir_receiver #(
  parameter int unsigned TIMEOUT_CYC = 100000,
  parameter logic [1:0]  DIR_RESET   = 2'b11
) (
  input logic                clk,
  input logic                RST,
  ps2_dir_receiver_if.master bus
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_prev;
  logic          fall;
  logic          data_bit;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          par_bit;
  logic [TW-1:0] tcnt;
  logic          ext;
  logic          brk;
  logic [1:0]    dir_q;
  logic          dir_valid_q;
  logic [7:0]    scan_q;
  logic          err_q;
  logic          frame_good;
  logic          timeout_hit;
  logic [2:0]    hit;

  // Returns {hit, dir}; hit=0 means the code does not steer the snake.
  function automatic logic [2:0] lookup(input logic [7:0] code, input logic is_ext);
    logic [2:0] r;
    r = 3'b000;
    if (is_ext) begin
      case (code)
        8'h75:   r = 3'b100;
        8'h72:   r = 3'b101;
        8'h6B:   r = 3'b110;
        8'h74:   r = 3'b111;
        default: r = 3'b000;
      endcase
    end
`ifdef PS2_WASD_EN
    else begin
      case (code)
        8'h1D:   r = 3'b100;
        8'h1B:   r = 3'b101;
        8'h1C:   r = 3'b110;
        8'h23:   r = 3'b111;
        default: r = 3'b000;
      endcase
    end
`endif
    return r;
  endfunction

  // Synchronisers idle high so a reset never fakes a falling edge.
  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[0], bus.PS2_CLK};
      data_sync <= {data_sync[0], bus.PS2_DATA};
      clk_prev  <= clk_sync[1];
    end
  end

  assign fall     = clk_prev & ~clk_sync[1];
  assign data_bit = data_sync[1];

  // Frame is judged on the stop-bit fall so the result lands one cycle later.
  assign frame_good  = fall && (state == STOP) && data_bit && (^{shreg, par_bit});
  assign timeout_hit = !fall && (state != IDLE) && (tcnt == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    hit = lookup(shreg, ext);
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state       <= IDLE;
      shreg       <= 8'h00;
      bitcnt      <= 3'd0;
      par_bit     <= 1'b0;
      tcnt        <= '0;
      ext         <= 1'b0;
      brk         <= 1'b0;
      dir_q       <= DIR_RESET;
      dir_valid_q <= 1'b0;
      scan_q      <= 8'h00;
      err_q       <= 1'b0;
    end else begin
      dir_valid_q <= 1'b0;
      err_q       <= 1'b0;
      if (timeout_hit) begin
        state <= IDLE;
        tcnt  <= '0;
        err_q <= 1'b1;
        ext   <= 1'b0;
        brk   <= 1'b0;
      end else if (fall) begin
        tcnt <= '0;
        case (state)
          IDLE: begin
            // A high start bit is a line glitch and is silently ignored.
            if (!data_bit) begin
              state  <= DATA;
              bitcnt <= 3'd0;
            end
          end
          DATA: begin
            shreg  <= {data_bit, shreg[7:1]};
            bitcnt <= bitcnt + 3'd1;
            if (bitcnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
            par_bit <= data_bit;
            state   <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (frame_good) begin
              scan_q <= shreg;
              if (shreg == 8'hE0) begin
                ext <= 1'b1;
              end else if (shreg == 8'hF0) begin
                brk <= 1'b1;
              end else begin
                ext <= 1'b0;
                brk <= 1'b0;
                if (!brk && hit[2]) begin
                  dir_q       <= hit[1:0];
                  dir_valid_q <= 1'b1;
                end
              end
            end else begin
              err_q <= 1'b1;
              ext   <= 1'b0;
              brk   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end else if (state != IDLE) begin
        tcnt <= tcnt + 1'b1;
      end
    end
  end

  assign bus.DIR       = dir_q;
  assign bus.DIR_VALID = dir_valid_q;
  assign bus.SCAN      = scan_q;
  assign bus.ERR       = err_q;
  assign bus.fsm_state = state;

endmodule

// File: tb/tb_ps2_dir_receiver.sv
// Directed bench for ps2_dir_receiver: serialises PS/2 frames and checks DIR/SCAN/ERR behaviour.
// Build with PS2_WASD_EN defined to exercise the W/S/A/D mapping.
module tb_ps2_dir_receiver;

  localparam int unsigned TO = 200;

  logic clk;
  logic RST;
  int   n_asserts;
  int   n_fail;
  int   valid_cnt;
  int   err_cnt;
  int   both_cnt;
  int   v0;
  int   e0;

  ps2_dir_receiver_if bus ();

  ps2_dir_receiver #(
    .TIMEOUT_CYC(TO),
    .DIR_RESET  (2'b11)
  ) dut (
    .clk(clk),
    .RST(RST),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pulse monitor, sampled away from the active edge
  always @(negedge clk) begin
    if (bus.DIR_VALID === 1'b1) valid_cnt++;
    if (bus.ERR === 1'b1) err_cnt++;
    if (bus.DIR_VALID === 1'b1 && bus.ERR === 1'b1) both_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ps2_bit(input logic b);
    bus.PS2_DATA = b;
    #30;
    bus.PS2_CLK = 1'b0;
    #60;
    bus.PS2_CLK = 1'b1;
    #30;
  endtask

  task automatic ps2_frame(input logic [7:0] code, input logic bad_par, input logic bad_stop);
    logic p;
    p = ~(^code) ^ bad_par;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(code[i]);
    ps2_bit(p);
    ps2_bit(~bad_stop);
    bus.PS2_DATA = 1'b1;
    #100;
  endtask

  task automatic snap();
    v0 = valid_cnt;
    e0 = err_cnt;
  endtask

  initial begin
    n_asserts    = 0;
    n_fail       = 0;
    valid_cnt    = 0;
    err_cnt      = 0;
    both_cnt     = 0;
    RST          = 1'b0;
    bus.PS2_CLK  = 1'b1;
    bus.PS2_DATA = 1'b1;
    #50;
    RST = 1'b1;
    #50;

    // 1: reset in the middle of a frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    @(negedge clk);
    check("midframe_state", 32'(bus.fsm_state), 32'd1);
    RST = 1'b0;
    #40;
    @(negedge clk);
    check("rst_dir", 32'(bus.DIR), 32'h3);
    check("rst_scan", 32'(bus.SCAN), 32'h00);
    check("rst_state", 32'(bus.fsm_state), 32'd0);
    RST = 1'b1;
    snap();
    repeat (TO + 50) @(posedge clk);
    @(negedge clk);
    check("idle_no_err", 32'(err_cnt - e0), 32'd0);
    check("idle_dir", 32'(bus.DIR), 32'h3);
    check("idle_valid", 32'(bus.DIR_VALID), 32'd0);
    check("idle_err", 32'(bus.ERR), 32'd0);
    check("idle_scan", 32'(bus.SCAN), 32'h00);

    // 2: extended left arrow
    snap();
    ps2_frame(8'hE0, 1'b0, 1'b0);
    ps2_frame(8'h6B, 1'b0, 1'b0);
    @(negedge clk);
    check("left_valid_pulses", 32'(valid_cnt - v0), 32'd1);
    check("left_dir", 32'(bus.DIR), 32'h2);
    check("left_scan", 32'(bus.SCAN), 32'h6B);
    check("left_no_err", 32'(err_cnt - e0), 32'd0);

    // 3: break of up arrow does not steer
    snap();
    ps2_frame(8'hE0, 1'b0, 1'b0);
    ps2_frame(8'hF0, 1'b0, 1'b0);
    ps2_frame(8'h75, 1'b0, 1'b0);
    @(negedge clk);
    check("break_no_valid", 32'(valid_cnt - v0), 32'd0);
    check("break_dir", 32'(bus.DIR), 32'h2);
    check("break_scan", 32'(bus.SCAN), 32'h75);

    // 4: parity errors are dropped, then extended down arrow
    snap();
    ps2_frame(8'h75, 1'b1, 1'b0);
    ps2_frame(8'h6B, 1'b1, 1'b0);
    @(negedge clk);
    check("parity_err_pulses", 32'(err_cnt - e0), 32'd2);
    check("parity_scan_held", 32'(bus.SCAN), 32'h75);
    check("parity_dir_held", 32'(bus.DIR), 32'h2);
    snap();
    ps2_frame(8'hE0, 1'b0, 1'b0);
    ps2_frame(8'h72, 1'b0, 1'b0);
    @(negedge clk);
    check("down_dir", 32'(bus.DIR), 32'h1);
    check("down_valid_pulses", 32'(valid_cnt - v0), 32'd1);

    // 5: truncated frame times out once
    snap();
    ps2_bit(1'b0);
    for (int i = 0; i < 4; i++) ps2_bit(1'b1);
    repeat (TO + 50) @(posedge clk);
    @(negedge clk);
    check("timeout_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("timeout_state", 32'(bus.fsm_state), 32'd0);
    check("timeout_dir_held", 32'(bus.DIR), 32'h1);
    snap();
    ps2_frame(8'hE0, 1'b0, 1'b0);
    ps2_frame(8'h74, 1'b0, 1'b0);
    @(negedge clk);
    check("right_dir", 32'(bus.DIR), 32'h3);
    check("right_valid_pulses", 32'(valid_cnt - v0), 32'd1);

    // typematic repeat re-pulses with unchanged DIR
    snap();
    ps2_frame(8'hE0, 1'b0, 1'b0);
    ps2_frame(8'h74, 1'b0, 1'b0);
    @(negedge clk);
    check("repeat_valid_pulses", 32'(valid_cnt - v0), 32'd1);
    check("repeat_dir", 32'(bus.DIR), 32'h3);

    // 6: W key
    snap();
    ps2_frame(8'h1D, 1'b0, 1'b0);
    @(negedge clk);
    check("w_scan", 32'(bus.SCAN), 32'h1D);
`ifdef PS2_WASD_EN
    check("w_dir", 32'(bus.DIR), 32'h0);
    check("w_valid_pulses", 32'(valid_cnt - v0), 32'd1);
    snap();
    ps2_frame(8'hE0, 1'b0, 1'b0);
    ps2_frame(8'h1B, 1'b0, 1'b0);
    @(negedge clk);
    check("ext_s_ignored", 32'(valid_cnt - v0), 32'd0);
    check("ext_s_dir", 32'(bus.DIR), 32'h0);
`else
    check("w_dir_held", 32'(bus.DIR), 32'h3);
    check("w_no_valid", 32'(valid_cnt - v0), 32'd0);
`endif

    // bad stop bit after E0 clears the prefix
    snap();
    ps2_frame(8'hE0, 1'b0, 1'b0);
    ps2_frame(8'h72, 1'b0, 1'b1);
    @(negedge clk);
    check("stop_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("stop_scan_held", 32'(bus.SCAN), 32'hE0);
    snap();
    ps2_frame(8'h72, 1'b0, 1'b0);
    @(negedge clk);
    check("prefix_cleared", 32'(valid_cnt - v0), 32'd0);
    check("plain_scan", 32'(bus.SCAN), 32'h72);

    check("valid_err_exclusive", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
